// File: rtl/cpu_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : cpu_ifetch                                                     |
// | Description: Instruction fetch engine. Issues Wishbone-classic word reads  |
// |              and pushes the returned words into the instruction FIFO. It  |
// |              honours FIFO back-pressure and PC redirects. It realigns the |
// |              stream when a redirect targets an odd halfword.              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module cpu_ifetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00001000,
  parameter int unsigned MAX_WAIT     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_adr_o,
  output logic        imem_cyc_o,
  output logic        imem_stb_o,
  input  logic [31:0] imem_dat_i,
  input  logic        imem_ack_i,
  input  logic        fifo_full_i,
  output logic        fifo_write_en_o,
  output logic [31:0] fifo_data_o,
  output logic        fifo_flush_o,
  output logic        newPC_p_o,
  output logic [31:0] PC_o,
  input  logic        branch_i,
  input  logic [31:0] branch_tgt_i,
  input  logic        halt_i,
  output logic        bus_err_o
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    PUSH_WAIT = 2'd2
  } state_t;

  // Registered state
  state_t          state;
  logic [31:0]     adr;
  logic            cyc;
  logic [31:0]     fetch_addr;
  logic            misaligned;
  logic [15:0]     hold;
  logic            hold_v;
  logic [31:0]     pend_word;
  logic [CW-1:0]   wait_cnt;
  logic            bus_err;
  logic            write_en;
  logic [31:0]     data;
  logic            flush;
  logic            newpc;
  logic [31:0]     pc;

  // Next-state values
  state_t          state_nxt;
  logic [31:0]     adr_nxt;
  logic            cyc_nxt;
  logic [31:0]     fetch_addr_nxt;
  logic            misaligned_nxt;
  logic [15:0]     hold_nxt;
  logic            hold_v_nxt;
  logic [31:0]     pend_word_nxt;
  logic [CW-1:0]   wait_cnt_nxt;
  logic            bus_err_nxt;
  logic            write_en_nxt;
  logic [31:0]     data_nxt;
  logic            flush_nxt;
  logic            newpc_nxt;
  logic [31:0]     pc_nxt;
  logic [31:0]     word;

  // Next-state and output decode; a redirect overrides everything else
  always_comb begin
    state_nxt      = state;
    adr_nxt        = adr;
    cyc_nxt        = cyc;
    fetch_addr_nxt = fetch_addr;
    misaligned_nxt = misaligned;
    hold_nxt       = hold;
    hold_v_nxt     = hold_v;
    pend_word_nxt  = pend_word;
    wait_cnt_nxt   = wait_cnt;
    bus_err_nxt    = bus_err;
    write_en_nxt   = 1'b0;
    data_nxt       = data;
    flush_nxt      = 1'b0;
    newpc_nxt      = 1'b0;
    pc_nxt         = pc;
    // Realigned word: held lower halfword of the previous fetch, then the
    // lower-address halfword of the current one.
    word           = misaligned ? {hold, imem_dat_i[31:16]} : imem_dat_i;

    if (branch_i) begin
      state_nxt      = IDLE;
      cyc_nxt        = 1'b0;
      flush_nxt      = 1'b1;
      newpc_nxt      = 1'b1;
      pc_nxt         = branch_tgt_i;
      fetch_addr_nxt = {branch_tgt_i[31:2], 2'b00};
      misaligned_nxt = branch_tgt_i[1];
      hold_v_nxt     = 1'b0;
      wait_cnt_nxt   = '0;
      bus_err_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!halt_i && !fifo_full_i) begin
            state_nxt    = REQ;
            cyc_nxt      = 1'b1;
            adr_nxt      = fetch_addr;
            wait_cnt_nxt = '0;
          end
        end
        REQ: begin
          if (!cyc) begin
            // One-cycle gap after the priming fetch of a misaligned stream
            cyc_nxt      = 1'b1;
            adr_nxt      = fetch_addr;
            wait_cnt_nxt = '0;
          end else if (imem_ack_i) begin
            cyc_nxt        = 1'b0;
            wait_cnt_nxt   = '0;
            fetch_addr_nxt = fetch_addr + 32'd4;
            if (misaligned) begin
              hold_nxt   = imem_dat_i[15:0];
              hold_v_nxt = 1'b1;
            end
            if (misaligned && !hold_v) begin
              // Priming fetch: only the upper halfword of the target word is kept
              state_nxt = REQ;
            end else if (fifo_full_i) begin
              pend_word_nxt = word;
              state_nxt     = PUSH_WAIT;
            end else begin
              write_en_nxt = 1'b1;
              data_nxt     = word;
              state_nxt    = IDLE;
            end
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            // Timeout: abandon the cycle and retry the same address from IDLE
            bus_err_nxt  = 1'b1;
            cyc_nxt      = 1'b0;
            wait_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt + CW'(1);
          end
        end
        PUSH_WAIT: begin
          if (!fifo_full_i) begin
            write_en_nxt = 1'b1;
            data_nxt     = pend_word;
            state_nxt    = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cyc_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset drops the bus cycle immediately
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      adr        <= '0;
      cyc        <= 1'b0;
      fetch_addr <= BOOT_ADDRESS;
      misaligned <= 1'b0;
      hold       <= '0;
      hold_v     <= 1'b0;
      pend_word  <= '0;
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
      write_en   <= 1'b0;
      data       <= '0;
      flush      <= 1'b0;
      newpc      <= 1'b0;
      pc         <= '0;
    end else begin
      state      <= state_nxt;
      adr        <= adr_nxt;
      cyc        <= cyc_nxt;
      fetch_addr <= fetch_addr_nxt;
      misaligned <= misaligned_nxt;
      hold       <= hold_nxt;
      hold_v     <= hold_v_nxt;
      pend_word  <= pend_word_nxt;
      wait_cnt   <= wait_cnt_nxt;
      bus_err    <= bus_err_nxt;
      write_en   <= write_en_nxt;
      data       <= data_nxt;
      flush      <= flush_nxt;
      newpc      <= newpc_nxt;
      pc         <= pc_nxt;
    end
  end

  assign imem_adr_o      = adr;
  assign imem_cyc_o      = cyc;
  assign imem_stb_o      = cyc;
  assign fifo_write_en_o = write_en;
  assign fifo_data_o     = data;
  assign fifo_flush_o    = flush;
  assign newPC_p_o       = newpc;
  assign PC_o            = pc;
  assign bus_err_o       = bus_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ifetch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_cpu_ifetch                                                  |
// | Description: Directed bench for cpu_ifetch: aligned fetch table, FIFO      |
// |              back-pressure, redirects, realignment, timeout, wrap, halt.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cpu_ifetch;

  localparam int MAX_WAIT = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] imem_adr_o;
  logic        imem_cyc_o;
  logic        imem_stb_o;
  logic [31:0] imem_dat_i;
  logic        imem_ack_i;
  logic        fifo_full_i;
  logic        fifo_write_en_o;
  logic [31:0] fifo_data_o;
  logic        fifo_flush_o;
  logic        newPC_p_o;
  logic [31:0] PC_o;
  logic        branch_i;
  logic [31:0] branch_tgt_i;
  logic        halt_i;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  cpu_ifetch #(
    .BOOT_ADDRESS (32'h00001000),
    .MAX_WAIT     (MAX_WAIT)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_adr_o      (imem_adr_o),
    .imem_cyc_o      (imem_cyc_o),
    .imem_stb_o      (imem_stb_o),
    .imem_dat_i      (imem_dat_i),
    .imem_ack_i      (imem_ack_i),
    .fifo_full_i     (fifo_full_i),
    .fifo_write_en_o (fifo_write_en_o),
    .fifo_data_o     (fifo_data_o),
    .fifo_flush_o    (fifo_flush_o),
    .newPC_p_o       (newPC_p_o),
    .PC_o            (PC_o),
    .branch_i        (branch_i),
    .branch_tgt_i    (branch_tgt_i),
    .halt_i          (halt_i),
    .bus_err_o       (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          delay;
    logic [31:0] dat;
    logic [31:0] exp_adr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) at negedges until a bus cycle is visible
  task automatic wait_cyc();
    for (int i = 0; i < 40; i++) begin
      if (imem_cyc_o) return;
      @(negedge clk_i);
    end
    checks++;
    errors++;
    $display("FAIL wait_cyc: got no strobe expected strobe within 40 cycles");
  endtask

  // Serve one bus read: ack after delay cycles, report address and push seen
  task automatic do_fetch(input int delay, input logic [31:0] dat, input logic full,
                          output logic [31:0] adr, output logic we,
                          output logic [31:0] data);
    wait_cyc();
    adr = imem_adr_o;
    repeat (delay) @(negedge clk_i);
    imem_ack_i  = 1'b1;
    imem_dat_i  = dat;
    fifo_full_i = full;
    @(negedge clk_i);
    imem_ack_i  = 1'b0;
    we   = fifo_write_en_o;
    data = fifo_data_o;
  endtask

  logic [31:0] adr;
  logic        we;
  logic [31:0] data;
  int          cnt;
  logic        saw_cyc;

  initial begin
    vecs[0] = '{0, 32'h01020304, 32'h00001000, 32'h01020304};
    vecs[1] = '{2, 32'h11223344, 32'h00001004, 32'h11223344};
    vecs[2] = '{0, 32'hFFFF0000, 32'h00001008, 32'hFFFF0000};
    vecs[3] = '{5, 32'h00000000, 32'h0000100C, 32'h00000000};

    rst_i        = 1'b0;
    imem_dat_i   = '0;
    imem_ack_i   = 1'b0;
    fifo_full_i  = 1'b0;
    branch_i     = 1'b0;
    branch_tgt_i = '0;
    halt_i       = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset state
    chk("rst_cyc", {31'd0, imem_cyc_o}, 32'd0);
    chk("rst_adr", imem_adr_o, 32'd0);
    chk("rst_we", {31'd0, fifo_write_en_o}, 32'd0);
    chk("rst_flush", {31'd0, fifo_flush_o}, 32'd0);
    chk("rst_newpc", {31'd0, newPC_p_o}, 32'd0);
    chk("rst_err", {31'd0, bus_err_o}, 32'd0);
    rst_i = 1'b1;

    // Aligned fetches from the boot address
    for (int i = 0; i < 4; i++) begin
      do_fetch(vecs[i].delay, vecs[i].dat, 1'b0, adr, we, data);
      chk("tbl_adr", adr, vecs[i].exp_adr);
      chk("tbl_push", {31'd0, we}, 32'd1);
      chk("tbl_data", data, vecs[i].exp_data);
      @(negedge clk_i);
      chk("tbl_pulse", {31'd0, fifo_write_en_o}, 32'd0);
    end

    // FIFO full at ack: word held until full drops
    do_fetch(1, 32'hDEADBEEF, 1'b1, adr, we, data);
    chk("full_adr", adr, 32'h00001010);
    chk("full_nopush", {31'd0, we}, 32'd0);
    repeat (2) begin
      @(negedge clk_i);
      chk("full_hold_we", {31'd0, fifo_write_en_o}, 32'd0);
      chk("full_hold_cyc", {31'd0, imem_cyc_o}, 32'd0);
    end
    fifo_full_i = 1'b0;
    @(negedge clk_i);
    chk("full_push", {31'd0, fifo_write_en_o}, 32'd1);
    chk("full_data", fifo_data_o, 32'hDEADBEEF);
    @(negedge clk_i);
    chk("full_pulse", {31'd0, fifo_write_en_o}, 32'd0);
    chk("full_next_cyc", {31'd0, imem_cyc_o}, 32'd1);
    chk("full_next_adr", imem_adr_o, 32'h00001014);

    // Redirect with ack in the same cycle: ack data dropped
    imem_ack_i   = 1'b1;
    imem_dat_i   = 32'h12345678;
    branch_i     = 1'b1;
    branch_tgt_i = 32'h00003000;
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    branch_i   = 1'b0;
    chk("br_ack_nopush", {31'd0, fifo_write_en_o}, 32'd0);
    chk("br_ack_flush", {31'd0, fifo_flush_o}, 32'd1);
    chk("br_ack_newpc", {31'd0, newPC_p_o}, 32'd1);
    chk("br_ack_pc", PC_o, 32'h00003000);
    chk("br_ack_cyc", {31'd0, imem_cyc_o}, 32'd0);
    @(negedge clk_i);
    chk("br_flush_pulse", {31'd0, fifo_flush_o}, 32'd0);
    do_fetch(0, 32'h55667788, 1'b0, adr, we, data);
    chk("br_tgt_adr", adr, 32'h00003000);
    chk("br_tgt_data", data, 32'h55667788);

    // Redirect to an odd halfword: realigned stream
    branch_i     = 1'b1;
    branch_tgt_i = 32'h00002002;
    @(negedge clk_i);
    branch_i = 1'b0;
    chk("mis_flush", {31'd0, fifo_flush_o}, 32'd1);
    chk("mis_pc", PC_o, 32'h00002002);
    chk("mis_cyc", {31'd0, imem_cyc_o}, 32'd0);
    do_fetch(0, 32'hAAAABBBB, 1'b0, adr, we, data);
    chk("mis_prime_adr", adr, 32'h00002000);
    chk("mis_prime_nopush", {31'd0, we}, 32'd0);
    do_fetch(1, 32'hCCCCDDDD, 1'b0, adr, we, data);
    chk("mis_adr1", adr, 32'h00002004);
    chk("mis_push1", {31'd0, we}, 32'd1);
    chk("mis_data1", data, 32'hBBBBCCCC);
    do_fetch(0, 32'hEEEEFFFF, 1'b0, adr, we, data);
    chk("mis_adr2", adr, 32'h00002008);
    chk("mis_data2", data, 32'hDDDDEEEE);

    // Ack withheld: timeout after MAX_WAIT cycles, retry same address
    wait_cyc();
    chk("to_adr", imem_adr_o, 32'h0000200C);
    cnt = 0;
    while (imem_cyc_o && cnt < 40) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("to_cycles", cnt, MAX_WAIT);
    chk("to_err", {31'd0, bus_err_o}, 32'd1);
    do_fetch(0, 32'h11112222, 1'b0, adr, we, data);
    chk("to_retry_adr", adr, 32'h0000200C);
    chk("to_retry_data", data, 32'hFFFF1111);
    chk("to_err_sticky", {31'd0, bus_err_o}, 32'd1);

    // Redirect clears the error; address wraps; halt blocks new cycles
    branch_i     = 1'b1;
    branch_tgt_i = 32'hFFFFFFFC;
    @(negedge clk_i);
    branch_i = 1'b0;
    chk("wrap_err_clr", {31'd0, bus_err_o}, 32'd0);
    do_fetch(0, 32'hCAFEF00D, 1'b0, adr, we, data);
    chk("wrap_adr", adr, 32'hFFFFFFFC);
    chk("wrap_data", data, 32'hCAFEF00D);
    halt_i  = 1'b1;
    saw_cyc = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      if (imem_cyc_o) saw_cyc = 1'b1;
    end
    chk("halt_nocyc", {31'd0, saw_cyc}, 32'd0);
    halt_i = 1'b0;
    wait_cyc();
    chk("wrap_next_adr", imem_adr_o, 32'h00000000);

    // Asynchronous reset in the middle of a bus cycle
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_cyc", {31'd0, imem_cyc_o}, 32'd0);
    chk("arst_adr", imem_adr_o, 32'd0);
    @(negedge clk_i);
    chk("arst_we", {31'd0, fifo_write_en_o}, 32'd0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
